usb_gpx_event_ctrl: RTL and testbench



---
 rtl/usb_gpx_event_ctrl_if.sv | 22 ++
 rtl/usb_gpx_event_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_usb_gpx_event_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/usb_gpx_event_ctrl_if.sv
// Avalon-MM slave bus plus the GPX pin and the IRQ line of the GPX event controller.
// The master modport is the CPU/bench side and the slave modport is the controller side.
`timescale 1ns/1ps
interface usb_gpx_event_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        in_port;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata, in_port,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata, in_port,
        output readdata, irq
    );
endinterface

// File: rtl/usb_gpx_event_ctrl.sv
// MAX3421E GPX event controller: syncs GPX, detects a programmable edge, tracks pending/overflow/timeout and a count, and drives a level IRQ.
// Optional glitch filter after the synchronizer when USB_GPX_DEBOUNCE_EN is defined.
`timescale 1ns/1ps
module usb_gpx_event_ctrl #(
    parameter int                   SYNC_STAGES     = 2,
    parameter int                   TIMEOUT_W       = 16,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_RST     = 16'd50000,
    parameter int                   DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    usb_gpx_event_ctrl_if.slave   bus
);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
        $error("usb_gpx_event_ctrl: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_EXPIRED} state_t;

    localparam logic [TIMEOUT_W-1:0] TMR_ONE  = TIMEOUT_W'(1);
    localparam logic [TIMEOUT_W-1:0] TMR_ZERO = '0;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   gpx_s;
    logic                   gpx_dly_q, gpx_dly_d;
    logic [2:0]             ctrl_q, ctrl_d;
    logic [TIMEOUT_W-1:0]   tmo_reg_q, tmo_reg_d;
    logic [TIMEOUT_W-1:0]   timer_q, timer_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   pending_q, pending_d;
    logic                   overflow_q, overflow_d;
    logic                   timeout_q, timeout_d;
    logic                   irq_q, irq_d;
    logic [31:0]            readdata_q, readdata_d;
    state_t                 state_q, state_d;

    logic wr, wr_ctrl, wr_stat, wr_tmo;
    logic w1c_pend, w1c_ovf, w1c_tmo, cnt_clr;
    logic qual_edge, ovf_set, tmo_set;
    logic unused_wdata;

    assign unused_wdata = ^bus.writedata[31:17];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], bus.in_port};
    end

`ifdef USB_GPX_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic            gpx_f_q, gpx_f_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;

    // gpx_s follows the synchronizer only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        gpx_f_d  = gpx_f_q;
        db_cnt_d = '0;
        if (sync_q[SYNC_STAGES-1] != gpx_f_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                gpx_f_d = sync_q[SYNC_STAGES-1];
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpx_f_q  <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            gpx_f_q  <= gpx_f_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign gpx_s = gpx_f_q;
`else
    assign gpx_s = sync_q[SYNC_STAGES-1];
`endif

    assign wr       = bus.chipselect & ~bus.write_n;
    assign wr_ctrl  = wr & (bus.address == 2'd1);
    assign wr_stat  = wr & (bus.address == 2'd2);
    assign wr_tmo   = wr & (bus.address == 2'd3);
    assign w1c_pend = wr_stat & bus.writedata[0];
    assign w1c_ovf  = wr_stat & bus.writedata[1];
    assign w1c_tmo  = wr_stat & bus.writedata[2];
    assign cnt_clr  = wr_stat & bus.writedata[16];

    assign qual_edge = ctrl_q[1] ? (~gpx_s & gpx_dly_q) : (gpx_s & ~gpx_dly_q);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        tmo_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (qual_edge) begin
                    state_d = ST_WAIT;
                    timer_d = tmo_reg_q;
                end
            end
            ST_WAIT: begin
                if (qual_edge) begin
                    timer_d = tmo_reg_q;
                end else if (w1c_pend) begin
                    state_d = ST_IDLE;
                end else if (tmo_reg_q != TMR_ZERO) begin
                    // A zero TIMEOUT disables the watchdog, so the timer simply holds.
                    if (timer_q == TMR_ONE) begin
                        state_d = ST_EXPIRED;
                        timer_d = TMR_ZERO;
                        tmo_set = 1'b1;
                    end else if (timer_q != TMR_ZERO) begin
                        timer_d = timer_q - TMR_ONE;
                    end
                end
            end
            ST_EXPIRED: begin
                if (qual_edge) begin
                    state_d = ST_WAIT;
                    timer_d = tmo_reg_q;
                end else if (w1c_pend) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = TMR_ZERO;
            end
        endcase
    end

    // An edge coinciding with a W1C of pending counts as a fresh event, not an overflow.
    assign ovf_set = qual_edge & (state_q != ST_IDLE) & ~w1c_pend;

    always_comb begin
        gpx_dly_d  = gpx_s;
        ctrl_d     = wr_ctrl ? bus.writedata[2:0] : ctrl_q;
        tmo_reg_d  = wr_tmo ? bus.writedata[TIMEOUT_W-1:0] : tmo_reg_q;
        pending_d  = qual_edge ? 1'b1 : (w1c_pend ? 1'b0 : pending_q);
        overflow_d = ovf_set ? 1'b1 : (w1c_ovf ? 1'b0 : overflow_q);
        timeout_d  = tmo_set ? 1'b1 : (w1c_tmo ? 1'b0 : timeout_q);
        cnt_d      = cnt_q;
        if (cnt_clr) begin
            cnt_d = 8'd0;
        end else if (qual_edge && ctrl_q[2] && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
        irq_d = ctrl_q[0] & (pending_q | timeout_q);
        case (bus.address)
            2'd0:    readdata_d = {31'd0, gpx_s};
            2'd1:    readdata_d = {29'd0, ctrl_q};
            2'd2:    readdata_d = {16'd0, cnt_q, 5'd0, timeout_q, overflow_q, pending_q};
            default: readdata_d = {{(32-TIMEOUT_W){1'b0}}, tmo_reg_q};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q     <= '0;
            gpx_dly_q  <= 1'b0;
            ctrl_q     <= 3'd0;
            tmo_reg_q  <= TIMEOUT_RST;
            timer_q    <= '0;
            cnt_q      <= 8'd0;
            pending_q  <= 1'b0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
            irq_q      <= 1'b0;
            readdata_q <= 32'd0;
            state_q    <= ST_IDLE;
        end else begin
            sync_q     <= sync_d;
            gpx_dly_q  <= gpx_dly_d;
            ctrl_q     <= ctrl_d;
            tmo_reg_q  <= tmo_reg_d;
            timer_q    <= timer_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
            irq_q      <= irq_d;
            readdata_q <= readdata_d;
            state_q    <= state_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.irq      = irq_q;

endmodule

// File: tb/tb_usb_gpx_event_ctrl.sv
// Directed bench for usb_gpx_event_ctrl: register reset values, edge latency, watchdog, overflow, count saturation and reset.
`timescale 1ns/1ps
module tb_usb_gpx_event_ctrl;

`ifdef USB_GPX_DEBOUNCE_EN
    localparam int EXTRA = 4;
`else
    localparam int EXTRA = 0;
`endif
    localparam int L = 2 + 1 + EXTRA;   // pin change to pending set, in cycles
    localparam int H = 6 + EXTRA;       // settle time between pin changes
    localparam int P = 2 + EXTRA;       // half-period of the edge train

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] rdat;

    usb_gpx_event_ctrl_if bus ();

    usb_gpx_event_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Both tasks are entered and left on a falling edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'd0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.address = a;
        @(negedge clk);
        d = bus.readdata;
    endtask

    initial begin
        reset          = 1'b1;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'd0;
        bus.in_port    = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_irq", {31'd0, bus.irq}, 32'd0);
        check("rst_readdata", bus.readdata, 32'd0);
        reset = 1'b0;

        rd(2'd0, rdat); check("rst_data", rdat, 32'd0);
        rd(2'd1, rdat); check("rst_ctrl", rdat, 32'd0);
        rd(2'd2, rdat); check("rst_status", rdat, 32'd0);
        rd(2'd3, rdat); check("rst_timeout", rdat, 32'd50000);
        check("rst_irq_after", {31'd0, bus.irq}, 32'd0);

        // Rising-edge latency and IRQ one cycle after pending.
        wr(2'd1, 32'h5);
        rd(2'd1, rdat); check("ctrl_rb", rdat, 32'h5);
        bus.address = 2'd2;
        @(negedge clk);
        bus.in_port = 1'b1;
        repeat (L) @(negedge clk);
        check("irq_pre", {31'd0, bus.irq}, 32'd0);
        check("status_pre", bus.readdata, 32'h0);
        @(negedge clk);
        check("irq_edge", {31'd0, bus.irq}, 32'd1);
        check("status_edge", bus.readdata, 32'h0000_0101);
        rd(2'd0, rdat); check("data_high", rdat, 32'd1);

        // Watchdog: timeout exactly 10 cycles after pending.
        bus.in_port = 1'b0;
        repeat (H) @(negedge clk);
        wr(2'd3, 32'd10);
        wr(2'd2, 32'h0001_0007);
        rd(2'd2, rdat); check("status_cleared", rdat, 32'h0);
        bus.in_port = 1'b1;
        repeat (L + 10) @(negedge clk);
        check("tmo_pre", bus.readdata, 32'h0000_0101);
        @(negedge clk);
        check("tmo_set", bus.readdata, 32'h0000_0105);
        check("tmo_irq", {31'd0, bus.irq}, 32'd1);
        wr(2'd2, 32'h5);
        @(negedge clk);
        check("w1c_irq_low", {31'd0, bus.irq}, 32'd0);
        rd(2'd2, rdat); check("w1c_status", rdat, 32'h0000_0100);

        // Overflow on a second edge; coincident W1C of pending with a third edge.
        wr(2'd3, 32'd0);
        wr(2'd2, 32'h0001_0007);
        bus.in_port = 1'b0; repeat (H) @(negedge clk);
        bus.in_port = 1'b1; repeat (H) @(negedge clk);
        rd(2'd2, rdat); check("first_edge", rdat, 32'h0000_0101);
        bus.in_port = 1'b0; repeat (H) @(negedge clk);
        bus.in_port = 1'b1; repeat (H) @(negedge clk);
        rd(2'd2, rdat); check("overflow", rdat, 32'h0000_0203);
        wr(2'd2, 32'h2);
        rd(2'd2, rdat); check("ovf_w1c", rdat, 32'h0000_0201);
        bus.in_port = 1'b0; repeat (H) @(negedge clk);
        bus.in_port = 1'b1;
        repeat (L - 1) @(negedge clk);
        wr(2'd2, 32'h1);
        rd(2'd2, rdat); check("coincident_w1c", rdat, 32'h0000_0301);

        // Falling-edge select, then count saturation and clear.
        bus.in_port = 1'b0; repeat (H) @(negedge clk);
        wr(2'd2, 32'h0001_0007);
        wr(2'd1, 32'h7);
        bus.in_port = 1'b1; repeat (H) @(negedge clk);
        rd(2'd2, rdat); check("fall_rise_ignored", rdat, 32'h0);
        bus.in_port = 1'b0; repeat (H) @(negedge clk);
        rd(2'd2, rdat); check("fall_event", rdat, 32'h0000_0101);
        for (int i = 0; i < 300; i++) begin
            bus.in_port = 1'b1; repeat (P) @(negedge clk);
            bus.in_port = 1'b0; repeat (P) @(negedge clk);
        end
        repeat (H) @(negedge clk);
        rd(2'd2, rdat); check("count_sat", rdat, 32'h0000_FF03);
        wr(2'd2, 32'h0001_0000);
        rd(2'd2, rdat); check("count_clear", rdat, 32'h0000_0003);

`ifdef USB_GPX_DEBOUNCE_EN
        wr(2'd2, 32'h0001_0007);
        wr(2'd1, 32'h5);
        bus.in_port = 1'b1; repeat (3) @(negedge clk);
        bus.in_port = 1'b0; repeat (12) @(negedge clk);
        rd(2'd2, rdat); check("glitch_3", rdat, 32'h0);
        bus.in_port = 1'b1; repeat (4) @(negedge clk);
        bus.in_port = 1'b0; repeat (12) @(negedge clk);
        rd(2'd2, rdat); check("pulse_4", rdat, 32'h0000_0101);
`endif

        // Asynchronous reset mid-operation.
        check("irq_before_reset", {31'd0, bus.irq}, 32'd1);
        reset = 1'b1;
        #1;
        check("async_rst_irq", {31'd0, bus.irq}, 32'd0);
        check("async_rst_rdata", bus.readdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rd(2'd2, rdat); check("post_rst_status", rdat, 32'h0);
        rd(2'd1, rdat); check("post_rst_ctrl", rdat, 32'h0);
        rd(2'd3, rdat); check("post_rst_timeout", rdat, 32'd50000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
